// File: rtl/zueirai_gpio_pkg.sv
// zueirai_gpio_pkg: register map constants and port selectors for the GPIO register block
package zueirai_gpio_pkg;
  localparam logic [1:0] REG_DIR = 2'd0;
  localparam logic [1:0] REG_OUT = 2'd1;
  localparam logic [1:0] REG_IN  = 2'd2;
  localparam logic [1:0] REG_IE  = 2'd3;
  localparam logic [1:0] PORT_IF = 2'd3;
  typedef enum logic [1:0] {PORT_A, PORT_B, PORT_C} port_e;
  function automatic logic [3:0] reg_addr(input logic [1:0] port, input logic [1:0] r);
    return {port, r};
  endfunction
endpackage

// File: rtl/zueirai_gpio_sync.sv
// zueirai_gpio_sync: pin synchronizer chain plus previous-sample register yielding per-bit toggles
module zueirai_gpio_sync #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] toggle
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] ff;
  logic [WIDTH-1:0] prev;
  // shift pins through the chain; prev lags the synchronized value by one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ff   <= '0;
      prev <= '0;
    end else begin
      ff   <= {ff[SYNC_STAGES-2:0], din};
      prev <= ff[SYNC_STAGES-1];
    end
  assign sync   = ff[SYNC_STAGES-1];
  assign toggle = sync ^ prev;
endmodule

// File: rtl/zueirai_gpio_regs.sv
// zueirai_gpio_regs: CPU register block for ports A/B/C with synchronized inputs and change interrupt
module zueirai_gpio_regs
  import zueirai_gpio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             we,
  input  logic             re,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic [WIDTH-1:0] dir_a,
  output logic [WIDTH-1:0] dir_b,
  output logic [WIDTH-1:0] dir_c,
  output logic [WIDTH-1:0] dout_a,
  output logic [WIDTH-1:0] dout_b,
  output logic [WIDTH-1:0] dout_c,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din_c,
  output logic             irq
);
  logic [WIDTH-1:0] dir_q[4], out_q[4], ie_q[4], if_q[4], sync_q[4], din_v[3];
  logic [WIDTH-1:0] rd;
  assign din_v[0]  = din_a;
  assign din_v[1]  = din_b;
  assign din_v[2]  = din_c;
  assign dir_q[3]  = '0;
  assign out_q[3]  = '0;
  assign ie_q[3]   = '0;
  assign if_q[3]   = '0;
  assign sync_q[3] = '0;
  assign {dir_a, dir_b, dir_c}    = {dir_q[0], dir_q[1], dir_q[2]};
  assign {dout_a, dout_b, dout_c} = {out_q[0], out_q[1], out_q[2]};
  genvar g;
  for (g = 0; g < 3; g++) begin : g_port
    logic [WIDTH-1:0] dir_r, out_r, ie_r, if_r, tgl, dir_nxt, clr;
    zueirai_gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst_n(rst_n), .din(din_v[g]), .sync(sync_q[g]), .toggle(tgl)
    );
    assign dir_nxt = (we && addr == reg_addr(2'(g), REG_DIR)) ? wdata : dir_r;
    assign clr     = (we && addr == reg_addr(PORT_IF, 2'(g))) ? wdata : '0;
    // a bit flags only while it is an input both before and after any DIR write this cycle; set beats clear
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        dir_r <= DIR_RESET;
        out_r <= '0;
        ie_r  <= '0;
        if_r  <= '0;
      end else begin
        dir_r <= dir_nxt;
        out_r <= (we && addr == reg_addr(2'(g), REG_OUT)) ? wdata : out_r;
        ie_r  <= (we && addr == reg_addr(2'(g), REG_IE)) ? wdata : ie_r;
        if_r  <= (if_r & ~clr) | (tgl & ie_r & ~dir_r & ~dir_nxt);
      end
    assign dir_q[g] = dir_r;
    assign out_q[g] = out_r;
    assign ie_q[g]  = ie_r;
    assign if_q[g]  = if_r;
  end
  always_comb
    rd = addr[3:2] == PORT_IF   ? if_q[addr[1:0]]   :
         addr[1:0] == REG_DIR   ? dir_q[addr[3:2]]  :
         addr[1:0] == REG_OUT   ? out_q[addr[3:2]]  :
         addr[1:0] == REG_IN    ? sync_q[addr[3:2]] : ie_q[addr[3:2]];
  // registered read port and interrupt level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
      irq    <= 1'b0;
    end else begin
      rvalid <= re;
      rdata  <= re ? rd : rdata;
      irq    <= |{if_q[0], if_q[1], if_q[2]};
    end
endmodule

// File: tb/tb_zueirai_gpio_regs.sv
// tb_zueirai_gpio_regs: scoreboard bench with a history-based reference model of the GPIO register block
module tb_zueirai_gpio_regs;
  import zueirai_gpio_pkg::*;
  localparam int W = 8;
  localparam int S = 2;
  logic clk = 0;
  logic rst_n;
  logic [3:0] addr;
  logic [W-1:0] wdata, rdata, dir_a, dir_b, dir_c, dout_a, dout_b, dout_c, din_a, din_b, din_c;
  logic we, re, rvalid, irq;
  int checks = 0;
  int fails = 0;
  logic [W-1:0] m_dir[3], m_out[3], m_ie[3], m_if[3];
  logic [W-1:0] hist[3][S+1];
  logic m_irq;
  logic [W-1:0] expq[$];

  zueirai_gpio_regs #(.WIDTH(W), .SYNC_STAGES(S), .DIR_RESET(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .rvalid(rvalid), .dir_a(dir_a), .dir_b(dir_b), .dir_c(dir_c),
    .dout_a(dout_a), .dout_b(dout_b), .dout_c(dout_c),
    .din_a(din_a), .din_b(din_b), .din_c(din_c), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] din_of(input int p);
    return p == 0 ? din_a : p == 1 ? din_b : din_c;
  endfunction

  task automatic m_reset();
    for (int p = 0; p < 3; p++) begin
      m_dir[p] = 8'h00;
      m_out[p] = '0;
      m_ie[p]  = '0;
      m_if[p]  = '0;
      for (int k = 0; k <= S; k++) hist[p][k] = '0;
    end
    m_irq = 0;
    expq.delete();
  endtask

  function automatic logic [W-1:0] m_read(input logic [3:0] a);
    int p;
    p = int'(a[3:2]);
    if (p == 3) return a[1:0] == 2'd3 ? '0 : m_if[a[1:0]];
    case (a[1:0])
      2'd0: return m_dir[p];
      2'd1: return m_out[p];
      2'd2: return hist[p][S-1];
      default: return m_ie[p];
    endcase
  endfunction

  task automatic m_step();
    logic nirq;
    logic [W-1:0] nd, chg, clr;
    if (re) expq.push_back(m_read(addr));
    nirq = (m_if[0] | m_if[1] | m_if[2]) != 0;
    for (int p = 0; p < 3; p++) begin
      nd  = (we && addr == {p[1:0], 2'd0}) ? wdata : m_dir[p];
      chg = (hist[p][S-1] ^ hist[p][S]) & m_ie[p] & ~m_dir[p] & ~nd;
      clr = (we && addr == {2'd3, p[1:0]}) ? wdata : '0;
      m_if[p]  = (m_if[p] & ~clr) | chg;
      m_dir[p] = nd;
      if (we && addr == {p[1:0], 2'd1}) m_out[p] = wdata;
      if (we && addr == {p[1:0], 2'd3}) m_ie[p] = wdata;
      for (int k = S; k > 0; k--) hist[p][k] = hist[p][k-1];
      hist[p][0] = din_of(p);
    end
    m_irq = nirq;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_step();
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d);
    addr = a; wdata = d; we = 1; tick(); we = 0;
  endtask

  task automatic rd(input logic [3:0] a);
    addr = a; re = 1; tick(); re = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  always @(negedge clk) begin
    chk("dir_a", dir_a, m_dir[0]);
    chk("dir_b", dir_b, m_dir[1]);
    chk("dir_c", dir_c, m_dir[2]);
    chk("dout_a", dout_a, m_out[0]);
    chk("dout_b", dout_b, m_out[1]);
    chk("dout_c", dout_c, m_out[2]);
    chk("irq", {7'd0, irq}, {7'd0, m_irq});
    if (rvalid) begin
      if (expq.size() == 0) begin
        checks++; fails++;
        $display("FAIL spurious_rvalid: got rvalid=1 rdata=%h expected no read", rdata);
      end else chk("rdata", rdata, expq.pop_front());
    end else if (expq.size() != 0) begin
      checks++; fails++;
      $display("FAIL missing_rvalid: got rvalid=0 expected read data %h", expq[0]);
      expq.delete();
    end
  end

  initial begin
    addr = 0; wdata = 0; we = 0; re = 0;
    din_a = 0; din_b = 0; din_c = 0;
    rst_n = 1;
    #1 rst_n = 0;
    m_reset();
    idle(2);
    rst_n = 1;
    idle(1);
    rd(reg_addr(PORT_A, REG_DIR));
    idle(1);
    wr(reg_addr(PORT_A, REG_DIR), 8'hF0);
    wr(reg_addr(PORT_A, REG_OUT), 8'hA5);
    chk("dir_a_f0", dir_a, 8'hF0);
    chk("dout_a_a5", dout_a, 8'hA5);
    rd(reg_addr(PORT_A, REG_DIR));
    rd(reg_addr(PORT_A, REG_OUT));
    din_b = 8'h3C;
    repeat (S + 2) rd(reg_addr(PORT_B, REG_IN));
    wr(reg_addr(PORT_C, REG_IE), 8'h01);
    wr(reg_addr(PORT_C, REG_DIR), 8'h00);
    din_c = 8'h01;
    idle(S + 2);
    chk("irq_on_c", {7'd0, irq}, 8'h01);
    rd(reg_addr(PORT_IF, 2'd2));
    wr(reg_addr(PORT_IF, 2'd2), 8'h01);
    idle(1);
    chk("irq_clr_c", {7'd0, irq}, 8'h00);
    rd(reg_addr(PORT_IF, 2'd2));
    wr(reg_addr(PORT_C, REG_DIR), 8'h01);
    din_c = 8'h00;
    idle(S + 2);
    rd(reg_addr(PORT_IF, 2'd2));
    chk("irq_out_mode", {7'd0, irq}, 8'h00);
    wr(reg_addr(PORT_A, REG_IE), 8'h04);
    wr(reg_addr(PORT_A, REG_DIR), 8'h00);
    din_a = din_a ^ 8'h04;
    idle(S + 2);
    din_a = din_a ^ 8'h04;
    idle(S);
    wr(reg_addr(PORT_IF, 2'd0), 8'h04);
    rd(reg_addr(PORT_IF, 2'd0));
    idle(1);
    chk("irq_collide", {7'd0, irq}, 8'h01);
    wr(reg_addr(PORT_IF, 2'd0), 8'h04);
    idle(2);
    chk("irq_after_w1c", {7'd0, irq}, 8'h00);
    wr(reg_addr(PORT_A, REG_OUT), 8'h5A);
    addr = reg_addr(PORT_A, REG_OUT); re = 1; tick(); re = 0;
    rst_n = 0;
    m_reset();
    #1;
    chk("rst_rvalid", {7'd0, rvalid}, 8'h00);
    chk("rst_dir_a", dir_a, 8'h00);
    chk("rst_dout_a", dout_a, 8'h00);
    idle(2);
    rst_n = 1;
    rd(4'hF);
    wr(4'hF, 8'hFF);
    rd(4'hF);
    idle(2);
    repeat (3000) begin
      we = $urandom_range(0, 3) == 0;
      re = $urandom_range(0, 2) == 0;
      addr = 4'($urandom);
      wdata = 8'($urandom);
      if ($urandom_range(0, 3) == 0) din_a = 8'($urandom);
      if ($urandom_range(0, 3) == 0) din_b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) din_c = 8'($urandom);
      tick();
    end
    we = 0; re = 0;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/zueirai_gpio_regs.md
Name: zueirai_gpio_regs

Overview:
- CPU-facing register block that controls the ZueiraI I/O pad mapper.
- Holds direction and output latches for ports A/B/C.
- Synchronizes the values read back from the pads and raises a change interrupt.
- Top level gates each DATA_x bit: dout_x drives DATA_x[i] only where dir_x[i]=1; din_x is taken from DATA_x otherwise.

Parameters:
- WIDTH, 8, bits per port.
- SYNC_STAGES, 2, flops in the input synchronizer chain (minimum 2).
- DIR_RESET, 8'h00, reset value of every DIR register (0 = input).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  4  register address.
- wdata  input  WIDTH  write data.
- we  input  1  write strobe, single cycle.
- re  input  1  read strobe, single cycle.
- rdata  output  WIDTH  read data, registered.
- rvalid  output  1  rdata valid, one cycle.
- dir_a/dir_b/dir_c  output  WIDTH each  direction to the pad mapper (1 = drive pin).
- dout_a/dout_b/dout_c  output  WIDTH each  output latch values.
- din_a/din_b/din_c  input  WIDTH each  asynchronous pin values from the pad mapper.
- irq  output  1  level interrupt, registered.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - DIR = DIR_RESET; OUT, IE, IF = 0.
  - Synchronizer flops and previous-sample flops = 0.
  - rdata = 0, rvalid = 0, irq = 0.
- Address map: addr[3:2] = port (0=A, 1=B, 2=C), addr[1:0] = register:
  - 0 = DIR (R/W)
  - 1 = OUT (R/W)
  - 2 = IN (RO, synchronized pin value)
  - 3 = IE (R/W)
- addr[3:2]=3 selects the flag registers:
  - addr[1:0] 0..2 = IF_A/IF_B/IF_C, write-1-to-clear.
  - addr 0xF reserved: reads 0, writes ignored.
- Writes:
  - Register updates on the clk edge where we=1; new value is visible on dir_x/dout_x the next cycle.
  - Writes to IN are ignored.
- Reads:
  - re=1 in cycle N → rdata/rvalid asserted in cycle N+1.
  - rvalid low otherwise; rdata holds its last value.
- Simultaneous we and re to the same address: the read returns the pre-write value.
- Input path:
  - din_x passes through SYNC_STAGES flops → sync_x.
  - prev_x holds sync_x delayed by one cycle.
  - IN register reads sync_x.
  - Latency from a pin change to IN visibility is SYNC_STAGES cycles.
- Change detect:
  - chg = (sync_x ^ prev_x) & IE_x & ~DIR_x.
  - IF_x |= chg each cycle.
- IF clear:
  - A W1C write clears the written-1 bits.
  - If set and clear hit the same bit in the same cycle, set wins (flag stays 1).
- irq = registered OR of all IF bits; deasserts the cycle after the last flag clears.
- Output-mode bits never set IF, including the cycle DIR changes.
- Edges present in the synchronizer at reset release are not flagged, because prev starts at 0 and sync starts at 0.
- Reset asserted mid-transaction aborts the read: rvalid = 0 immediately.

Decomposition:
- Package zueirai_gpio_pkg:
  - Register offset constants: REG_DIR, REG_OUT, REG_IN, REG_IE.
  - PORT_IF selector (3).
  - Port index enum: PORT_A, PORT_B, PORT_C.
- Sub-module zueirai_gpio_sync:
  - One instance per port.
  - Parameterized WIDTH/SYNC_STAGES.
  - Outputs sync and the edge vector.

Test Plan:
- Reset: rst_n=0 then release → dir_a/b/c=00, dout_*=00, irq=0, read addr 0x0 returns 00 with rvalid one cycle after re.
- Write DIR_A=F0, OUT_A=A5 → dir_a=F0 and dout_a=A5 the cycle after each we; reads of 0x0/0x1 return F0/A5.
- Set din_b=3C with DIR_B=00 → read of 0x6 returns 00 before SYNC_STAGES cycles have elapsed and 3C after.
- IE_C=01, DIR_C=00, toggle din_c[0] 0→1 → IF_C=01, irq=1.
  - Write 01 to 0xE → IF_C=00, irq=0 one cycle later.
  - Same test with DIR_C=01 → no flag.
- W1C write to IF_A bit 2 in the same cycle a new bit-2 edge arrives → IF_A[2] stays 1, irq stays 1.
- rst_n pulsed low while re is pending → rvalid=0, all registers return to reset values asynchronously; read 0xF returns 00.
